coproc_top: RTL and testbench

Programmable micro-sequenced modular-arithmetic core with host-loaded data RAM and command memory. It serves as the top level of the arithmetic coprocessor. The host works in four modes: load operand words, load a command program, execute the program from an entry point chosen by the instruction type, and read results back two words per cycle.

---
 rtl/coproc_top.sv | 217 +++++++++++++++++++++
 tb/tb_coproc_top.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/coproc_top.sv
`default_nettype none
// ============================================================================
//  Module   : coproc_top
//  Purpose  : Micro-sequenced modular-arithmetic coprocessor top level.
//             The host loads operand words and a command program, then runs
//             the program from an entry point chosen by the instruction type.
//             Results are read back two words per cycle.
//  Revision : 1.0  initial release
// ============================================================================
module coproc_top #(
  parameter int                     WORD_SIZE     = 32,
  parameter int                     RAM_ADDR_SIZE = 6,
  parameter int                     CMD_MEMSIZE   = 8,
  parameter int                     CMD_SIZE      = 4 + 3 * RAM_ADDR_SIZE,
  parameter logic [WORD_SIZE-1:0]   MODULUS       = 32'hFFFFFFFB,
  parameter int                     ENTRY_FE      = 128
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [1:0]                I_INPUTMODE,
  input  logic [1:0]                I_INSTTYPE,
  input  logic [CMD_MEMSIZE-1:0]    I_MODE_WADDR,
  input  logic [CMD_SIZE-1:0]       I_MODE_WDATA,
  input  logic [RAM_ADDR_SIZE-1:0]  I_WADDR1,
  input  logic [RAM_ADDR_SIZE-1:0]  I_WADDR2,
  input  logic [WORD_SIZE-1:0]      I_WDATA1,
  input  logic [WORD_SIZE-1:0]      I_WDATA2,
  input  logic [RAM_ADDR_SIZE-1:0]  I_RADDR1,
  input  logic [RAM_ADDR_SIZE-1:0]  I_RADDR2,
  output logic [WORD_SIZE-1:0]      outdata1,
  output logic [WORD_SIZE-1:0]      outdata2,
  output logic                      is_busy
);

  // Host modes
  localparam logic [1:0] C_MODE_COORD = 2'd0;
  localparam logic [1:0] C_MODE_CMD   = 2'd1;
  localparam logic [1:0] C_MODE_EXEC  = 2'd2;
  localparam logic [1:0] C_MODE_REF   = 2'd3;

  // Sequencer states
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_READ  = 3'd2;
  localparam logic [2:0] ST_EXEC  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // Opcodes
  localparam logic [3:0] C_OP_MADD = 4'd1;
  localparam logic [3:0] C_OP_MSUB = 4'd2;
  localparam logic [3:0] C_OP_MOV  = 4'd3;
  localparam logic [3:0] C_OP_XOR  = 4'd4;
  localparam logic [3:0] C_OP_AND  = 4'd5;
  localparam logic [3:0] C_OP_SHR1 = 4'd6;
  localparam logic [3:0] C_OP_HALT = 4'd15;

  localparam logic [CMD_MEMSIZE-1:0] C_ENTRY_FE = CMD_MEMSIZE'(ENTRY_FE);
  localparam logic [CMD_MEMSIZE-1:0] C_PC_ONE   = CMD_MEMSIZE'(1);

  // Storage
  logic [WORD_SIZE-1:0] ram_q  [0:(2**RAM_ADDR_SIZE)-1];
  logic [CMD_SIZE-1:0]  cmem_q [0:(2**CMD_MEMSIZE)-1];

  // Sequencer and readback registers
  logic [2:0]             state_q, state_d;
  logic [CMD_MEMSIZE-1:0] pc_q,    pc_d;
  logic [CMD_SIZE-1:0]    cmd_q,   cmd_d;
  logic [WORD_SIZE-1:0]   op_a_q,  op_a_d;
  logic [WORD_SIZE-1:0]   op_b_q,  op_b_d;
  logic [WORD_SIZE-1:0]   out1_q,  out1_d;
  logic [WORD_SIZE-1:0]   out2_q,  out2_d;

  // Decoded command fields
  logic [3:0]               w_opcode;
  logic [RAM_ADDR_SIZE-1:0] w_dst;
  logic [RAM_ADDR_SIZE-1:0] w_src1;
  logic [RAM_ADDR_SIZE-1:0] w_src2;

  logic                     w_mode_exec;
  logic                     w_host_data_we;
  logic                     w_host_cmd_we;
  logic                     w_exec_we;
  logic [WORD_SIZE:0]       w_sum;
  logic [WORD_SIZE-1:0]     w_result;

  assign w_opcode = cmd_q[CMD_SIZE-1 -: 4];
  assign w_dst    = cmd_q[3*RAM_ADDR_SIZE-1 -: RAM_ADDR_SIZE];
  assign w_src1   = cmd_q[2*RAM_ADDR_SIZE-1 -: RAM_ADDR_SIZE];
  assign w_src2   = cmd_q[RAM_ADDR_SIZE-1:0];

  assign is_busy  = (state_q == ST_FETCH) || (state_q == ST_READ) || (state_q == ST_EXEC);
  assign outdata1 = out1_q;
  assign outdata2 = out2_q;

  assign w_mode_exec    = (I_INPUTMODE == C_MODE_EXEC);
  assign w_host_data_we = (I_INPUTMODE == C_MODE_COORD) && !is_busy;
  assign w_host_cmd_we  = (I_INPUTMODE == C_MODE_CMD)   && !is_busy;
  // An abort cycle (mode left EXEC) must not commit the result.
  assign w_exec_we      = (state_q == ST_EXEC) && w_mode_exec &&
                          (w_opcode >= C_OP_MADD) && (w_opcode <= C_OP_SHR1);

  // One extra bit keeps the carry of the modular add visible.
  assign w_sum = {1'b0, op_a_q} + {1'b0, op_b_q};

  // ALU: compute the result of the instruction held in cmd_q
  always_comb begin
    w_result = '0;
    case (w_opcode)
      C_OP_MADD: w_result = (w_sum >= {1'b0, MODULUS}) ? (w_sum[WORD_SIZE-1:0] - MODULUS)
                                                        : w_sum[WORD_SIZE-1:0];
      C_OP_MSUB: w_result = (op_a_q < op_b_q) ? (op_a_q - op_b_q + MODULUS)
                                              : (op_a_q - op_b_q);
      C_OP_MOV:  w_result = op_a_q;
      C_OP_XOR:  w_result = op_a_q ^ op_b_q;
      C_OP_AND:  w_result = op_a_q & op_b_q;
      C_OP_SHR1: w_result = op_a_q >> 1;
      default:   w_result = '0;
    endcase
  end

  // Next-state logic for the sequencer and readback registers
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cmd_d   = cmd_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    out1_d  = out1_q;
    out2_d  = out2_q;

    if (I_INPUTMODE == C_MODE_REF) begin
      out1_d = ram_q[I_RADDR1];
      out2_d = ram_q[I_RADDR2];
    end

    case (state_q)
      ST_IDLE: begin
        if (w_mode_exec) begin
          pc_d    = (I_INSTTYPE == 2'd1) ? C_ENTRY_FE : '0;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (!w_mode_exec) begin
          state_d = ST_IDLE;
        end else begin
          cmd_d   = cmem_q[pc_q];
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        if (!w_mode_exec) begin
          state_d = ST_IDLE;
        end else begin
          op_a_d  = ram_q[w_src1];
          op_b_d  = ram_q[w_src2];
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (!w_mode_exec) begin
          state_d = ST_IDLE;
        end else begin
          pc_d    = pc_q + C_PC_ONE;
          state_d = (w_opcode == C_OP_HALT) ? ST_DONE : ST_FETCH;
        end
      end
      ST_DONE: begin
        if (!w_mode_exec) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer and readback registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      cmd_q   <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      out1_q  <= '0;
      out2_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cmd_q   <= cmd_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      out1_q  <= out1_d;
      out2_q  <= out2_d;
    end
  end

  // Data RAM writes; port 2 is assigned last so it wins on equal addresses
  always_ff @(posedge clk) begin
    if (w_host_data_we) begin
      ram_q[I_WADDR1] <= I_WDATA1;
      ram_q[I_WADDR2] <= I_WDATA2;
    end
    if (w_exec_we) begin
      ram_q[w_dst] <= w_result;
    end
  end

  // Command memory writes from the host
  always_ff @(posedge clk) begin
    if (w_host_cmd_we) begin
      cmem_q[I_MODE_WADDR] <= I_MODE_WDATA;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_coproc_top.sv
`default_nettype none
// ============================================================================
//  Module   : tb_coproc_top
//  Purpose  : Self-checking bench for coproc_top. A second instance uses
//             ENTRY_FE=255 to exercise program-counter wrap.
//  Revision : 1.0  initial release
// ============================================================================
module tb_coproc_top;

  localparam logic [31:0] C_MOD = 32'hFFFFFFFB;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode;
  logic [1:0]  itype;
  logic [7:0]  mwaddr;
  logic [21:0] mwdata;
  logic [5:0]  wa1, wa2, ra1, ra2;
  logic [31:0] wd1, wd2;
  logic [31:0] o1, o2, wo1, wo2;
  logic        busy, wbusy;

  always #5 clk = ~clk;

  coproc_top u_dut (
    .clk(clk), .rst(rst), .I_INPUTMODE(mode), .I_INSTTYPE(itype),
    .I_MODE_WADDR(mwaddr), .I_MODE_WDATA(mwdata),
    .I_WADDR1(wa1), .I_WADDR2(wa2), .I_WDATA1(wd1), .I_WDATA2(wd2),
    .I_RADDR1(ra1), .I_RADDR2(ra2),
    .outdata1(o1), .outdata2(o2), .is_busy(busy)
  );

  coproc_top #(.ENTRY_FE(255)) u_wrap (
    .clk(clk), .rst(rst), .I_INPUTMODE(mode), .I_INSTTYPE(itype),
    .I_MODE_WADDR(mwaddr), .I_MODE_WDATA(mwdata),
    .I_WADDR1(wa1), .I_WADDR2(wa2), .I_WDATA1(wd1), .I_WDATA2(wd2),
    .I_RADDR1(ra1), .I_RADDR2(ra2),
    .outdata1(wo1), .outdata2(wo2), .is_busy(wbusy)
  );

  int checks   = 0;
  int failures = 0;

  logic [31:0] model_ram  [64];
  logic [21:0] model_cmem [256];
  logic [31:0] exp_q [$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [21:0] mk_cmd(input logic [3:0] op, input logic [5:0] d,
                                         input logic [5:0] s1, input logic [5:0] s2);
    return {op, d, s1, s2};
  endfunction

  // Reference interpreter: returns instructions executed up to and including HALT
  function automatic int model_run(input logic [7:0] entry, input bit commit);
    logic [31:0] mr [64];
    logic [7:0]  pc;
    logic [21:0] c;
    logic [63:0] a, b;
    int          n;
    mr = model_ram;
    pc = entry;
    n  = 0;
    for (int k = 0; k < 256; k++) begin
      c = model_cmem[pc];
      n++;
      a = {32'd0, mr[c[11:6]]};
      b = {32'd0, mr[c[5:0]]};
      if (c[21:18] == 4'd15) break;
      case (c[21:18])
        4'd1: mr[c[17:12]] = 32'((a + b) % {32'd0, C_MOD});
        4'd2: mr[c[17:12]] = 32'((a + {32'd0, C_MOD} - b) % {32'd0, C_MOD});
        4'd3: mr[c[17:12]] = a[31:0];
        4'd4: mr[c[17:12]] = a[31:0] ^ b[31:0];
        4'd5: mr[c[17:12]] = a[31:0] & b[31:0];
        4'd6: mr[c[17:12]] = {1'b0, a[31:1]};
        default: ;
      endcase
      pc = pc + 8'd1;
    end
    if (commit) model_ram = mr;
    return n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_data(input logic [5:0] a1, input logic [31:0] d1,
                         input logic [5:0] a2, input logic [31:0] d2);
    mode = 2'd0; wa1 = a1; wd1 = d1; wa2 = a2; wd2 = d2;
    model_ram[a1] = d1;
    model_ram[a2] = d2;
    tick();
    mode = 2'd3;
  endtask

  task automatic wr_cmd(input logic [7:0] a, input logic [21:0] d);
    mode = 2'd1; mwaddr = a; mwdata = d;
    model_cmem[a] = d;
    tick();
    mode = 2'd3;
  endtask

  task automatic readback(input logic [5:0] a1, input logic [5:0] a2, input string tag);
    mode = 2'd3; ra1 = a1; ra2 = a2;
    exp_q.push_back(model_ram[a1]);
    exp_q.push_back(model_ram[a2]);
    tick();
    check_val({tag, "_out1"}, o1, exp_q.pop_front());
    check_val({tag, "_out2"}, o2, exp_q.pop_front());
  endtask

  // Hold EXEC for a fixed window; busy counts cover both the run length and
  // the absence of any restart while parked in DONE.
  task automatic run_exec(input logic [1:0] it, input string tag);
    int n_main, n_wrap, bm, bw;
    n_wrap = model_run((it == 2'd1) ? 8'd255 : 8'd0, 1'b0);
    n_main = model_run((it == 2'd1) ? 8'd128 : 8'd0, 1'b1);
    bm = 0; bw = 0;
    mode = 2'd2; itype = it;
    repeat (60) begin
      tick();
      if (busy)  bm++;
      if (wbusy) bw++;
    end
    check_val({tag, "_busy_cycles"},      32'(bm), 32'(3 * n_main));
    check_val({tag, "_wrap_busy_cycles"}, 32'(bw), 32'(3 * n_wrap));
    check_val({tag, "_done_idle"},        {31'd0, busy}, 32'd0);
    mode = 2'd3;
    tick();
  endtask

  initial begin
    for (int i = 0; i < 64; i++)  model_ram[i]  = 32'd0;
    for (int i = 0; i < 256; i++) model_cmem[i] = mk_cmd(4'd15, 6'd0, 6'd0, 6'd0);
    rst = 1'b1; mode = 2'd3; itype = 2'd0; mwaddr = 8'd0; mwdata = 22'd0;
    wa1 = 6'd0; wa2 = 6'd0; wd1 = 32'd0; wd2 = 32'd0; ra1 = 6'd0; ra2 = 6'd0;

    // Reset
    tick(); tick();
    check_val("rst_out1", o1, 32'd0);
    check_val("rst_out2", o2, 32'd0);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    tick();

    // Load and readback
    wr_data(6'd0, 32'hFFFFFFFA, 6'd1, 32'd2);
    readback(6'd0, 6'd1, "load");
    wr_data(6'd5, 32'd5, 6'd5, 32'd9);
    readback(6'd5, 6'd5, "same_addr");

    // Known contents for destination/scratch words
    wr_data(6'd2, 32'd0, 6'd3, 32'd0);
    wr_data(6'd4, 32'd0, 6'd6, 32'h1234);
    wr_data(6'd8, 32'h88, 6'd9, 32'h99);
    wr_cmd(8'd255, mk_cmd(4'd15, 6'd0, 6'd0, 6'd0));

    // ML program
    wr_cmd(8'd0, mk_cmd(4'd1, 6'd2, 6'd0, 6'd1));
    wr_cmd(8'd1, mk_cmd(4'd2, 6'd3, 6'd1, 6'd0));
    wr_cmd(8'd2, mk_cmd(4'd15, 6'd0, 6'd0, 6'd0));
    run_exec(2'd0, "ml");
    readback(6'd2, 6'd3, "ml_result");

    // FE entry
    wr_cmd(8'd128, mk_cmd(4'd3, 6'd4, 6'd1, 6'd0));
    wr_cmd(8'd129, mk_cmd(4'd15, 6'd0, 6'd0, 6'd0));
    wr_cmd(8'd0,   mk_cmd(4'd15, 6'd0, 6'd0, 6'd0));
    run_exec(2'd1, "fe");
    readback(6'd4, 6'd4, "fe_result");

    // Abort during READ, with a host write attempted in the same cycle
    wr_cmd(8'd0, mk_cmd(4'd1, 6'd6, 6'd0, 6'd1));
    wr_cmd(8'd1, mk_cmd(4'd15, 6'd0, 6'd0, 6'd0));
    mode = 2'd2; itype = 2'd0;
    tick();
    tick();
    check_val("abort_busy_in_read", {31'd0, busy}, 32'd1);
    mode = 2'd0; wa1 = 6'd8; wd1 = 32'hBAD; wa2 = 6'd8; wd2 = 32'hBAD;
    tick();
    check_val("abort_busy_low", {31'd0, busy}, 32'd0);
    mode = 2'd3;
    tick();
    readback(6'd6, 6'd8, "abort_lockout");

    // PC wrap on the ENTRY_FE=255 instance
    wr_cmd(8'd255, mk_cmd(4'd0, 6'd0, 6'd0, 6'd0));
    wr_cmd(8'd0,   mk_cmd(4'd15, 6'd0, 6'd0, 6'd0));
    run_exec(2'd1, "wrap");
    readback(6'd4, 6'd2, "wrap_result");

    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
